controle_ciclo: RTL and testbench
=================================

Name: controle_ciclo

Overview:
- Multicycle control FSM that sequences instruction execution around the program-counter update block `endereco`.
- Emits one `cp_en` pulse per instruction to gate the PC update, a load strobe for the instruction register, and register-file/memory write strobes.
- Handles memory wait states, a blocking user-input handshake and a halt/resume mechanism.
- Also keeps a count of retired instructions.

Parameters:
- MEM_LAT, default 1: extra wait cycles for a memory access. Legal range 0..3.
- ICNT_WIDTH, default 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- dec_halt  in  1  decoded flag: halt instruction.
- dec_in  in  1  decoded flag: input instruction (waits on user data).
- dec_mem_read  in  1  decoded flag: memory load.
- dec_mem_write  in  1  decoded flag: memory store.
- dec_reg_write  in  1  decoded flag: instruction writes the register file.
- in_valid  in  1  user input data is available.
- resume  in  1  leave the halted state.
- in_ack  out  1  input consumed (one cycle).
- ir_load  out  1  latch instruction register.
- cp_en  out  1  enable PC update in `endereco` for this cycle.
- reg_write_en  out  1  register-file write strobe.
- mem_read_en  out  1  data-memory read strobe.
- mem_write_en  out  1  data-memory write strobe.
- halted  out  1  processor halted.
- estado  out  3  current state code, for debug display.
- instr_count  out  ICNT_WIDTH  retired-instruction count.

Behaviour:
- Clock and reset are fixed: one clock, `clock`; `reset` is asynchronous and active-high.
- Reset:
  - state ← INICIO; instr_count ← 0; wait counter ← 0.
  - All strobes and `halted` are 0 while reset is high and in INICIO.
  - Reset asserted mid-instruction aborts it immediately; no strobe pulse is completed.
- State codes: INICIO=6, BUSCA=0, DECODIFICA=1, MEMORIA=2, ESPERA=3, ESCRITA=4, PARADO=5, PAUSA=7 (PAUSA exists only with the optional feature).
- Outputs are Moore decodes of the state. `in_ack` is the one exception and is Mealy.
- Transitions:
  - INICIO → BUSCA unconditionally, 1 cycle after reset release.
  - BUSCA: ir_load=1 → DECODIFICA.
  - DECODIFICA branches with priority dec_halt > dec_in > (dec_mem_read | dec_mem_write) > none:
    - dec_halt → PARADO.
    - dec_in → ESPERA.
    - memory access → MEMORIA; wait counter ← 0.
    - none → ESCRITA.
  - MEMORIA:
    - Asserts mem_write_en if dec_mem_write, else mem_read_en. If both flags are set, write wins and read stays 0.
    - Wait counter increments each cycle; at count==MEM_LAT → ESCRITA.
    - MEMORIA therefore lasts MEM_LAT+1 cycles.
  - ESPERA: stays while in_valid=0. When in_valid=1: in_ack=1 in the same cycle → ESCRITA.
  - ESCRITA:
    - cp_en=1; reg_write_en = dec_reg_write & ~dec_halt.
    - instr_count+1, wrapping modulo 2^ICNT_WIDTH → BUSCA.
  - PARADO: halted=1, all strobes 0. resume=1 → ESCRITA, which advances the PC past the halt and counts it as retired.
- Latency:
  - Plain instruction: 3 cycles.
  - Memory instruction: 3+MEM_LAT+1 cycles.
  - Input instruction: 3+N cycles, where N is the number of cycles until in_valid (minimum 1).
- Decoder flags are driven from the instruction register and must be stable from DECODIFICA through ESCRITA. The FSM does not sample or latch them.
- cp_en is high in exactly one cycle per retired instruction. The branch/jump decision stays in `endereco`.
- in_valid held high across consecutive input instructions: each instruction produces exactly one in_ack.
- resume asserted outside PARADO is ignored.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port `passo` (1 bit).
  - ESCRITA → PAUSA instead of BUSCA.
  - PAUSA holds all strobes at 0; passo=1 → BUSCA.
  - Reset while in PAUSA → INICIO.
- Undefined: no `passo` port, no PAUSA state; behaviour exactly as above.

Decomposition:
- Package `controle_pkg`:
  - 3-bit state localparams (codes above).
  - Parameter defaults MEM_LAT_DEF=1 and ICNT_WIDTH_DEF=16.
- One natural sub-module: `contador_instrucoes`, a parameterised wrapping counter with async reset and increment enable.
- The FSM and wait counter stay in `controle_ciclo`.

Test Plan:
- Reset, then plain instruction with dec_reg_write=1, MEM_LAT=1 → estado sequence 6,0,1,4,0. ir_load in cycle 2; cp_en and reg_write_en in cycle 4; instr_count=1.
- Load (dec_mem_read=1), MEM_LAT=2 → mem_read_en high exactly 3 cycles, then one cp_en. Total 6 cycles from BUSCA to next BUSCA.
- dec_in=1, in_valid raised after 5 cycles → in_ack for exactly 1 cycle, coincident with in_valid. cp_en on the following cycle; estado=3 during the wait.
- dec_halt=1 and dec_mem_write=1 together → PARADO (estado=5), halted=1, mem_write_en never asserted. resume=1 → one cp_en, reg_write_en=0, back to BUSCA.
- Reset asserted during MEMORIA → all strobes 0 immediately, estado=6, instr_count=0. Also preload instr_count=16'hFFFF, retire one instruction → 0.
- With SINGLE_STEP_EN: after ESCRITA, estado=7 held for 10 cycles with no strobes. passo pulse → BUSCA next cycle.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle control unit.
//   - 3-bit state codes shown on the `estado` debug output
//   - parameter defaults for the memory latency and the retired-instruction counter
//   - state enumeration used by the control FSM
//   - small decode helper for the memory-access branch
package controle_pkg;

    localparam logic [2:0] COD_BUSCA      = 3'd0;
    localparam logic [2:0] COD_DECODIFICA = 3'd1;
    localparam logic [2:0] COD_MEMORIA    = 3'd2;
    localparam logic [2:0] COD_ESPERA     = 3'd3;
    localparam logic [2:0] COD_ESCRITA    = 3'd4;
    localparam logic [2:0] COD_PARADO     = 3'd5;
    localparam logic [2:0] COD_INICIO     = 3'd6;
    localparam logic [2:0] COD_PAUSA      = 3'd7;

    localparam int MEM_LAT_DEF    = 1;
    localparam int ICNT_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        BUSCA      = COD_BUSCA,
        DECODIFICA = COD_DECODIFICA,
        MEMORIA    = COD_MEMORIA,
        ESPERA     = COD_ESPERA,
        ESCRITA    = COD_ESCRITA,
        PARADO     = COD_PARADO,
        INICIO     = COD_INICIO,
        PAUSA      = COD_PAUSA
    } estado_t;

    // An instruction needs the data-memory phase when it loads or stores.
    function automatic logic acesso_memoria(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/contador_instrucoes.sv
// Wrapping up-counter with asynchronous active-high reset and increment enable.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset, clears the count
//   en     in   add one on this clock edge
//   count  out  WIDTH-bit count, wraps modulo 2^WIDTH
module contador_instrucoes #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count register: increments when enabled, wraps naturally on overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/controle_ciclo.sv
// Multicycle control FSM sequencing instruction execution around the PC
// update block `endereco`. One cp_en pulse per retired instruction.
// Optional build macro: SINGLE_STEP_EN adds the `passo` input and the PAUSA
// state, so the machine stops after every instruction until `passo` is seen.
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   dec_halt/in/mem_read/mem_write/reg_write  decoded instruction flags
//                                (held stable by the IR from DECODIFICA to ESCRITA)
//   in_valid / in_ack            user-input handshake (in_ack is combinational)
//   resume                       leave PARADO
//   ir_load, cp_en               IR latch strobe, PC update enable
//   reg_write_en, mem_read_en, mem_write_en  write/read strobes
//   halted                       high while in PARADO
//   estado                       current 3-bit state code for debug display
//   instr_count                  retired-instruction count
//   passo (SINGLE_STEP_EN only)  advance from PAUSA to the next fetch
module controle_ciclo
    import controle_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int ICNT_WIDTH = ICNT_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dec_halt,
    input  logic                  dec_in,
    input  logic                  dec_mem_read,
    input  logic                  dec_mem_write,
    input  logic                  dec_reg_write,
    input  logic                  in_valid,
    input  logic                  resume,
`ifdef SINGLE_STEP_EN
    input  logic                  passo,
`endif
    output logic                  in_ack,
    output logic                  ir_load,
    output logic                  cp_en,
    output logic                  reg_write_en,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic                  halted,
    output logic [2:0]            estado,
    output logic [ICNT_WIDTH-1:0] instr_count
);

    localparam logic [1:0] LAT_FIM = 2'(MEM_LAT);

    estado_t    state_r;
    estado_t    next_state_s;
    logic [1:0] wait_r;

    logic ir_load_s;
    logic cp_en_s;
    logic reg_write_en_s;
    logic mem_read_en_s;
    logic mem_write_en_s;
    logic halted_s;

    // Next-state logic; decoder priority is halt > input > memory > plain.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            INICIO:     next_state_s = BUSCA;
            BUSCA:      next_state_s = DECODIFICA;
            DECODIFICA: begin
                if (dec_halt) begin
                    next_state_s = PARADO;
                end else if (dec_in) begin
                    next_state_s = ESPERA;
                end else if (acesso_memoria(dec_mem_read, dec_mem_write)) begin
                    next_state_s = MEMORIA;
                end else begin
                    next_state_s = ESCRITA;
                end
            end
            MEMORIA: begin
                if (wait_r == LAT_FIM) begin
                    next_state_s = ESCRITA;
                end else begin
                    next_state_s = MEMORIA;
                end
            end
            ESPERA: begin
                if (in_valid) begin
                    next_state_s = ESCRITA;
                end else begin
                    next_state_s = ESPERA;
                end
            end
`ifdef SINGLE_STEP_EN
            ESCRITA:    next_state_s = PAUSA;
            PAUSA: begin
                if (passo) begin
                    next_state_s = BUSCA;
                end else begin
                    next_state_s = PAUSA;
                end
            end
`else
            ESCRITA:    next_state_s = BUSCA;
            PAUSA:      next_state_s = BUSCA;
`endif
            PARADO: begin
                if (resume) begin
                    next_state_s = ESCRITA;
                end else begin
                    next_state_s = PARADO;
                end
            end
            default:    next_state_s = INICIO;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= INICIO;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Memory wait counter: cleared on decode, counts cycles spent in MEMORIA.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_r <= 2'd0;
        end else if (state_r == DECODIFICA) begin
            wait_r <= 2'd0;
        end else if (state_r == MEMORIA) begin
            wait_r <= wait_r + 2'd1;
        end else begin
            wait_r <= wait_r;
        end
    end

    // Strobe decode of the state being entered. Registering this gives the
    // same timing as decoding the current state, because the flags it reads
    // are held stable by the IR for the whole instruction.
    always_comb begin
        ir_load_s      = 1'b0;
        cp_en_s        = 1'b0;
        reg_write_en_s = 1'b0;
        mem_read_en_s  = 1'b0;
        mem_write_en_s = 1'b0;
        halted_s       = 1'b0;
        case (next_state_s)
            BUSCA:   ir_load_s = 1'b1;
            MEMORIA: begin
                // A store wins if both memory flags are set.
                mem_write_en_s = dec_mem_write;
                mem_read_en_s  = ~dec_mem_write;
            end
            ESCRITA: begin
                cp_en_s        = 1'b1;
                reg_write_en_s = dec_reg_write & ~dec_halt;
            end
            PARADO:  halted_s = 1'b1;
            default: ir_load_s = 1'b0;
        endcase
    end

    // Output registers; reset clears every strobe at once, aborting any
    // instruction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_load      <= 1'b0;
            cp_en        <= 1'b0;
            reg_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            halted       <= 1'b0;
        end else begin
            ir_load      <= ir_load_s;
            cp_en        <= cp_en_s;
            reg_write_en <= reg_write_en_s;
            mem_read_en  <= mem_read_en_s;
            mem_write_en <= mem_write_en_s;
            halted       <= halted_s;
        end
    end

    // Input acknowledge is Mealy so the user sees it in the same cycle as
    // in_valid; leaving ESPERA right after guarantees a single pulse.
    assign in_ack = (state_r == ESPERA) & in_valid;
    assign estado = state_r;

    contador_instrucoes #(
        .WIDTH (ICNT_WIDTH)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .en    (state_r == ESCRITA),
        .count (instr_count)
    );

endmodule

// File: tb/tb_controle_ciclo.sv
module tb_controle_ciclo;

    localparam int LAT = 2;
    localparam int W   = 4;
`ifdef SINGLE_STEP_EN
    localparam int SS  = 1;
`else
    localparam int SS  = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dec_halt = 1'b0, dec_in = 1'b0, dec_mem_read = 1'b0;
    logic dec_mem_write = 1'b0, dec_reg_write = 1'b0;
    logic in_valid = 1'b0, resume = 1'b0;
`ifdef SINGLE_STEP_EN
    logic passo = 1'b1;
`endif
    logic in_ack, ir_load, cp_en, reg_write_en, mem_read_en, mem_write_en, halted;
    logic [2:0] estado;
    logic [W-1:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    controle_ciclo #(.MEM_LAT(LAT), .ICNT_WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .dec_halt(dec_halt), .dec_in(dec_in), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
        .in_valid(in_valid), .resume(resume),
`ifdef SINGLE_STEP_EN
        .passo(passo),
`endif
        .in_ack(in_ack), .ir_load(ir_load), .cp_en(cp_en),
        .reg_write_en(reg_write_en), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .halted(halted),
        .estado(estado), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    // Runs one instruction. Entry: just after sampling a BUSCA cycle.
    // Exit: just after sampling the next BUSCA cycle.
    // n = wait cycles in ESPERA or PARADO; keep = in_valid held high throughout.
    task automatic run_instr(input bit f_halt, input bit f_in, input bit f_rd,
                             input bit f_wr, input bit f_reg, input int n, input bit keep);
        int exp_total, exp_first, exp_rd, exp_wr, exp_ack, exp_hlt, exp_reg;
        int c, cnt_cp, cp_at, cnt_rd, cnt_wr, cnt_ack, cnt_hlt, cnt_reg, first;
        bit done;
        exp_rd = 0; exp_wr = 0; exp_ack = 0; exp_hlt = 0;
        exp_reg = (f_reg && !f_halt) ? 1 : 0;
        if (f_halt) begin
            exp_first = 5; exp_total = 3 + n; exp_hlt = n;
        end else if (f_in) begin
            exp_first = 3; exp_total = 3 + n; exp_ack = 1;
        end else if (f_rd || f_wr) begin
            exp_first = 2; exp_total = 4 + LAT;
            if (f_wr) exp_wr = LAT + 1; else exp_rd = LAT + 1;
        end else begin
            exp_first = 4; exp_total = 3;
        end
        exp_total = exp_total + SS;

        n_tests++;
        if (estado !== 3'd0 || ir_load !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busca: estado=%0d ir_load=%b, required estado=0 ir_load=1", estado, ir_load);
        end
        dec_halt = f_halt; dec_in = f_in; dec_mem_read = f_rd;
        dec_mem_write = f_wr; dec_reg_write = f_reg;
        c = 0; done = 1'b0; first = -1; cp_at = -1;
        cnt_cp = 0; cnt_rd = 0; cnt_wr = 0; cnt_ack = 0; cnt_hlt = 0; cnt_reg = 0;
        while (!done && c < 60) begin
            c++;
            @(negedge clock);
            in_valid = f_in && (keep || c >= n + 1);
            resume = f_halt ? (c >= n + 1) : 1'($urandom_range(0, 1));
            #1;
            if (estado === 3'd0) begin
                done = 1'b1;
            end else begin
                if (c == 2) first = int'(estado);
                if (cp_en === 1'b1) begin cnt_cp++; cp_at = c; end
                if (reg_write_en === 1'b1) cnt_reg++;
                if (mem_read_en === 1'b1) cnt_rd++;
                if (mem_write_en === 1'b1) cnt_wr++;
                if (in_ack === 1'b1) cnt_ack++;
                if (halted === 1'b1) cnt_hlt++;
            end
        end
        if (!keep) in_valid = 1'b0;
        resume = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: no return to BUSCA within 60 cycles");
        end
        exp_cnt = (exp_cnt + 1) % (1 << W);
        n_tests++;
        if (c !== exp_total) begin
            n_fail++; $display("FAIL cycles: got %0d, required %0d", c, exp_total);
        end
        n_tests++;
        if (first !== exp_first) begin
            n_fail++; $display("FAIL first_state: got %0d, required %0d", first, exp_first);
        end
        n_tests++;
        if (cnt_cp !== 1 || cp_at !== exp_total - 1 - SS) begin
            n_fail++; $display("FAIL cp_en: pulses=%0d at=%0d, required 1 at %0d", cnt_cp, cp_at, exp_total - 1 - SS);
        end
        n_tests++;
        if (cnt_reg !== exp_reg) begin
            n_fail++; $display("FAIL reg_write: got %0d, required %0d", cnt_reg, exp_reg);
        end
        n_tests++;
        if (cnt_rd !== exp_rd || cnt_wr !== exp_wr) begin
            n_fail++; $display("FAIL mem_strobes: rd=%0d wr=%0d, required rd=%0d wr=%0d", cnt_rd, cnt_wr, exp_rd, exp_wr);
        end
        n_tests++;
        if (cnt_ack !== exp_ack || cnt_hlt !== exp_hlt) begin
            n_fail++; $display("FAIL ack_halt: ack=%0d halted=%0d, required ack=%0d halted=%0d", cnt_ack, cnt_hlt, exp_ack, exp_hlt);
        end
        n_tests++;
        if (instr_count !== W'(exp_cnt)) begin
            n_fail++; $display("FAIL instr_count: got %0d, required %0d", instr_count, exp_cnt);
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic [2:0] exp_est);
        n_tests++;
        if ({ir_load, cp_en, reg_write_en, mem_read_en, mem_write_en, halted, in_ack} !== 7'd0
            || estado !== exp_est) begin
            n_fail++;
            $display("FAIL %s: estado=%0d strobes=%b, required estado=%0d strobes=0", name, estado,
                     {ir_load, cp_en, reg_write_en, mem_read_en, mem_write_en, halted, in_ack}, exp_est);
        end
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle_outputs("after_release", 3'd6);
        @(negedge clock);
        #1;
        exp_cnt = 0;
        n_tests++;
        if (estado !== 3'd0 || instr_count !== '0) begin
            n_fail++; $display("FAIL first_busca: estado=%0d count=%0d, required 0 and 0", estado, instr_count);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #1;
        check_idle_outputs("in_reset", 3'd6);
        n_tests++;
        if (instr_count !== '0) begin
            n_fail++; $display("FAIL reset_count: got %0d, required 0", instr_count);
        end
        release_reset();
    endtask

    task automatic test_plain();
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_memory();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_input();
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b0);
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_halt();
        run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind;
            bit rd, wr;
            kind = int'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            case (kind)
                0: run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 0, 1'b0);
                1: run_instr(1'b0, 1'b0, rd | ~wr, wr, 1'($urandom_range(0, 1)), 0, 1'b0);
                2: run_instr(1'b0, 1'b1, rd, wr, 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), 1'b0);
                default: run_instr(1'b1, 1'($urandom_range(0, 1)), rd, wr, 1'($urandom_range(0, 1)),
                                   int'($urandom_range(1, 6)), 1'b0);
            endcase
        end
    endtask

    task automatic test_wrap();
        while (exp_cnt != (1 << W) - 1) run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        n_tests++;
        if (instr_count !== {W{1'b1}}) begin
            n_fail++; $display("FAIL wrap_pre: got %0d, required %0d", instr_count, (1 << W) - 1);
        end
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        n_tests++;
        if (instr_count !== '0) begin
            n_fail++; $display("FAIL wrap: got %0d, required 0", instr_count);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        if (exp_cnt == 0) run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        dec_mem_read = 1'b1; dec_mem_write = 1'b0; dec_halt = 1'b0; dec_in = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            #1;
            if (estado === 3'd2) seen = 1'b1;
        end
        n_tests++;
        if (!seen || mem_read_en !== 1'b1) begin
            n_fail++; $display("FAIL reach_memoria: seen=%b mem_read_en=%b, required 1 and 1", seen, mem_read_en);
        end
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid", 3'd6);
        n_tests++;
        if (instr_count !== '0) begin
            n_fail++; $display("FAIL reset_mid_count: got %0d, required 0", instr_count);
        end
        dec_mem_read = 1'b0;
        release_reset();
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        bit seen;
        seen = 1'b0;
        passo = 1'b0;
        dec_halt = 1'b0; dec_in = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_reg_write = 1'b1;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            #1;
            if (estado === 3'd7) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL reach_pausa: estado=%0d, required 7", estado);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            #1;
            check_idle_outputs("pausa_hold", 3'd7);
        end
        @(negedge clock);
        passo = 1'b1;
        @(negedge clock);
        #1;
        exp_cnt = (exp_cnt + 1) % (1 << W);
        n_tests++;
        if (estado !== 3'd0 || instr_count !== W'(exp_cnt)) begin
            n_fail++; $display("FAIL passo: estado=%0d count=%0d, required 0 and %0d", estado, instr_count, exp_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_plain();
        test_memory();
        test_input();
        test_halt();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
